// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fetch and data ports share one memory port.
// Data has priority; a starvation counter forces a fetch grant at STARVE_MAX.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state, state_nx;
  logic [3:0] starve, starve_nx;
  logic       grant_i, grant_d;

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nx  = state;
    starve_nx = starve;
    unique case (state)
      IDLE: begin
        if (d_req && !(i_req && starve == SMAX)) begin
          grant_d  = 1'b1;
          state_nx = BUSY_D;
          if (!i_req)
            starve_nx = 4'd0;
          else if (starve != 4'hF)
            starve_nx = starve + 4'd1;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nx  = BUSY_I;
          starve_nx = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starve    <= 4'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nx;
      starve <= starve_nx;
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
    end
  end

  // Acks exist only inside BUSY, so a stray mem_ack in IDLE is dropped.
  assign owner   = state;
  assign mem_req = (state != IDLE);
  assign i_ack   = (state == BUSY_I) && mem_ack;
  assign d_ack   = (state == BUSY_D) && mem_ack;
  assign i_rdata = i_ack ? mem_rdata : '0;
  assign d_rdata = d_ack ? mem_rdata : '0;
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester/memory models, scoreboard,
// reset-time vector table and multi-cycle corner sequences.
module tb_mem_port_arbiter;

  localparam logic [31:0] K    = 32'h2048_0005;
  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack, i_stall;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        ma;
    logic [31:0] mrd;
    logic [6:0]  want;
  } vec_t;

  txn_t iq[$], dq[$], iexp[$], dexp[$];
  int   grants[$], i_acks[$], d_acks[$], i_pres[$], d_pres[$];
  int   ncmp = 0, nbad = 0, cyc = 0, lat = 0, busy_cyc = 0;
  bit   auto_mem = 1'b1, stray = 1'b0;
  bit   i_cur = 1'b0, d_cur = 1'b0, i_seen = 1'b0, d_seen = 1'b0;
  bit   prev_req = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    ncmp++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] w);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = w;
    return t;
  endfunction

  function automatic bit busy();
    return iq.size() > 0 || dq.size() > 0 || i_cur || d_cur;
  endfunction

  task automatic clr();
    grants.delete(); i_acks.delete(); d_acks.delete();
    i_pres.delete(); d_pres.delete();
  endtask

  // Memory responder and requesters advance once per cycle after the edge.
  task automatic tick();
    txn_t t;
    @(posedge clk); #1;
    cyc++;
    if (!mem_req) begin
      busy_cyc  = 0;
      mem_ack   = stray;
      mem_rdata = JUNK;
    end else begin
      mem_ack   = auto_mem && (busy_cyc == lat);
      mem_rdata = mem_ack ? (mem_addr ^ K) : JUNK;
      busy_cyc++;
    end
    if (i_seen) begin i_cur = 1'b0; i_seen = 1'b0; end
    if (!i_cur) begin
      if (iq.size() > 0) begin
        t = iq.pop_front();
        i_req = 1'b1; i_addr = t.addr; i_cur = 1'b1;
        iexp.push_back(t); i_pres.push_back(cyc);
      end else i_req = 1'b0;
    end
    if (d_seen) begin d_cur = 1'b0; d_seen = 1'b0; end
    if (!d_cur) begin
      if (dq.size() > 0) begin
        t = dq.pop_front();
        d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
        d_cur = 1'b1;
        dexp.push_back(t); d_pres.push_back(cyc);
      end else d_req = 1'b0;
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin tick(); n++; end
    chk("drain_timeout", 64'(busy()), 0);
    tick(); tick();
  endtask

  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      chk("i_stall", i_stall, i_req & ~i_ack);
      chk("d_stall", d_stall, d_req & ~d_ack);
      chk("ack_outside_busy", (i_ack | d_ack) & ~mem_req, 0);
      if (mem_req && !prev_req) grants.push_back(int'(owner));
      if (i_ack) begin
        i_seen = 1'b1; i_acks.push_back(cyc);
        if (iexp.size() == 0) chk("i_ack_unexpected", i_ack, 0);
        else begin
          t = iexp.pop_front();
          chk("i_owner", owner, 1);
          chk("i_mem_we", mem_we, 0);
          chk("i_mem_addr", mem_addr, t.addr);
          chk("i_mem_wdata", mem_wdata, 0);
          chk("i_rdata", i_rdata, t.addr ^ K);
        end
      end else chk("i_rdata_gated", i_rdata, 0);
      if (d_ack) begin
        d_seen = 1'b1; d_acks.push_back(cyc);
        if (dexp.size() == 0) chk("d_ack_unexpected", d_ack, 0);
        else begin
          t = dexp.pop_front();
          chk("d_owner", owner, 2);
          chk("d_mem_we", mem_we, t.we);
          chk("d_mem_addr", mem_addr, t.addr);
          chk("d_mem_wdata", mem_wdata, t.we ? t.wdata : mem_wdata);
          if (!t.we) chk("d_rdata", d_rdata, t.addr ^ K);
        end
      end else chk("d_rdata_gated", d_rdata, 0);
    end
    prev_req = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   exp_g[12];
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #2;
    chk("rst_owner", owner, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);

    // {i_stall,d_stall,i_ack,d_ack,mem_req,owner} while held in reset
    tbl[0] = '{ir:0, dr:0, ma:0, mrd:32'h0,   want:7'b0000000};
    tbl[1] = '{ir:1, dr:0, ma:0, mrd:32'h0,   want:7'b1000000};
    tbl[2] = '{ir:0, dr:1, ma:1, mrd:'1,      want:7'b0100000};
    tbl[3] = '{ir:1, dr:1, ma:1, mrd:JUNK,    want:7'b1100000};
    tbl[4] = '{ir:1, dr:1, ma:0, mrd:JUNK,    want:7'b1100000};
    tbl[5] = '{ir:0, dr:0, ma:1, mrd:JUNK,    want:7'b0000000};
    for (int k = 0; k < 6; k++) begin
      i_req = tbl[k].ir; d_req = tbl[k].dr;
      mem_ack = tbl[k].ma; mem_rdata = tbl[k].mrd;
      #1;
      chk($sformatf("tbl%0d", k),
          {i_stall, d_stall, i_ack, d_ack, mem_req, owner}, tbl[k].want);
      chk($sformatf("tbl%0d_rdata", k), {i_rdata, d_rdata}, 0);
    end
    i_req = 0; d_req = 0; mem_ack = 0;
    tick();
    rst = 1'b0;

    // single fetch, memory answers two cycles after mem_req
    clr(); lat = 2;
    iq.push_back(mk(0, 32'h0040_0000, 0));
    drain(40);
    chk("fetch_acks", i_acks.size(), 1);
    chk("fetch_grants", grants.size(), 1);
    if (i_acks.size() == 1 && i_pres.size() == 1)
      chk("fetch_latency", i_acks[0] - i_pres[0], 3);
    chk("fetch_owner_end", owner, 0);

    // simultaneous fetch and data write: data first, one IDLE gap
    clr(); lat = 1;
    dq.push_back(mk(1, 32'h1000_0004, 32'hDEAD_BEEF));
    iq.push_back(mk(0, 32'h0040_0010, 0));
    drain(40);
    chk("conf_grants", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("conf_first", grants[0], 2);
      chk("conf_second", grants[1], 1);
    end
    if (d_acks.size() == 1 && i_acks.size() == 1 && d_pres.size() == 1) begin
      chk("conf_d_latency", d_acks[0] - d_pres[0], 2);
      chk("conf_gap", i_acks[0] - d_acks[0], 3);
    end

    // starvation: four data grants, one fetch, counter restarts
    clr(); lat = 0;
    for (int k = 0; k < 10; k++)
      dq.push_back(mk(k[0], 32'h1000_0100 + 32'(k * 4), 32'hA000_0000 + 32'(k)));
    iq.push_back(mk(0, 32'h0040_0100, 0));
    iq.push_back(mk(0, 32'h0040_0104, 0));
    drain(200);
    exp_g = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2, 2};
    chk("starve_count", grants.size(), 12);
    if (grants.size() == 12)
      for (int k = 0; k < 12; k++)
        chk($sformatf("starve_g%0d", k), grants[k], exp_g[k]);

    // back-to-back data accesses
    clr(); lat = 0;
    dq.push_back(mk(0, 32'h1000_0004, 0));
    dq.push_back(mk(0, 32'h1000_0008, 0));
    drain(40);
    chk("b2b_grants", grants.size(), 2);
    if (d_acks.size() == 2)
      chk("b2b_gap", d_acks[1] - d_acks[0], 2);

    // request dropped mid-access still completes
    clr(); lat = 3;
    dq.push_back(mk(0, 32'h1000_0010, 0));
    tick(); tick();
    d_req = 1'b0;
    drain(40);
    chk("drop_acks", d_acks.size(), 1);

    // stray acks in IDLE
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); #2;
      chk("stray_owner", owner, 0);
      chk("stray_acks", {i_ack, d_ack}, 0);
    end
    stray = 1'b0;
    tick();

    // reset in the second BUSY_D cycle, late mem_ack afterwards
    clr(); auto_mem = 1'b0;
    dq.push_back(mk(1, 32'h1000_0020, 32'h1234_5678));
    tick(); tick();
    chk("rmid_busy", {mem_req, owner}, 3'b110);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rmid_mem_req", mem_req, 0);
    chk("rmid_owner", owner, 0);
    chk("rmid_d_ack", d_ack, 0);
    chk("rmid_mem_addr", mem_addr, 0);
    d_req = 1'b0; d_cur = 1'b0; dexp.delete();
    tick(); tick();
    rst = 1'b0;
    stray = 1'b1;
    tick(); #2;
    chk("rmid_late_ack", {i_ack, d_ack}, 0);
    chk("rmid_late_owner", owner, 0);
    stray = 1'b0; auto_mem = 1'b1;
    tick();
    chk("rmid_d_acks", d_acks.size(), 0);

    // first grant right after reset release
    clr(); lat = 0;
    iq.push_back(mk(0, 32'h0040_0200, 0));
    drain(40);
    if (i_acks.size() == 1 && i_pres.size() == 1)
      chk("post_rst_latency", i_acks[0] - i_pres[0], 1);
    chk("post_rst_acks", i_acks.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending (range 1..15)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-high reset
- i_req, in, 1, instruction-fetch read request
- i_addr, in, ADDR_W, fetch address
- i_ack, out, 1, fetch complete, one-cycle pulse
- i_rdata, out, DATA_W, fetch data, valid while i_ack=1
- i_stall, out, 1, fetch waiting
- d_req, in, 1, data request
- d_we, in, 1, 1=write, 0=read
- d_addr, in, ADDR_W, data address
- d_wdata, in, DATA_W, write data
- d_ack, out, 1, data access complete, one-cycle pulse
- d_rdata, out, DATA_W, read data, valid while d_ack=1
- d_stall, out, 1, data access waiting
- mem_req, out, 1, shared-memory request, level
- mem_we, out, 1, shared-memory write enable
- mem_addr, out, ADDR_W, shared-memory address
- mem_wdata, out, DATA_W, shared-memory write data
- mem_ack, in, 1, memory done, one-cycle pulse
- mem_rdata, in, DATA_W, memory read data, valid with mem_ack
- owner, out, 2, 00=idle, 01=fetch, 10=data

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, BUSY_I, BUSY_D; owner SHALL equal the state encoding.
REQ-004 In IDLE with any request, the block SHALL select a grantee at the clock edge, latch that requester's addr, we, and wdata into output registers, and enter BUSY_I or BUSY_D. Fetch latches we=0 and wdata=0.
REQ-005 mem_req SHALL be 1 exactly while the state is BUSY_I or BUSY_D; mem_we, mem_addr, and mem_wdata SHALL hold their latched values throughout BUSY.
REQ-006 Priority: when both requests are present, d_req SHALL win unless the starvation counter equals STARVE_MAX, in which case i_req SHALL win.
REQ-007 Starvation counter (4 bits):
- increments, saturating, on each data grant made while i_req=1;
- clears on any fetch grant;
- clears on a data grant made with i_req=0.
REQ-008 In BUSY_x, when mem_ack=1, x_ack SHALL pulse in the same cycle, and x_rdata SHALL equal mem_rdata combinationally. The FSM SHALL return to IDLE at that edge.
REQ-009 Minimum latency: a request sampled at edge N gives mem_req=1 in cycle N. The earliest ack is in cycle N if mem_ack is returned immediately. There SHALL be one mandatory IDLE cycle between consecutive grants.
REQ-010 Requesters hold req and operands stable until ack. Requesters deassert or re-present req in the cycle after ack. A req still high in the ack cycle SHALL NOT be double-granted.
REQ-011 i_stall SHALL equal i_req & ~i_ack, and d_stall SHALL equal d_req & ~d_ack, both combinational.
REQ-012 mem_ack in IDLE SHALL be ignored: no ack pulse and no state change.
REQ-013 i_rdata and d_rdata SHALL be 0 when their ack is 0.
REQ-014 A write access SHALL complete on mem_ack exactly like a read; d_rdata is then don't-care but SHALL still be gated by REQ-013.
REQ-015 A request deasserted mid-BUSY (protocol violation) SHALL NOT abort the memory access; the block SHALL still wait for mem_ack.

Reset
REQ-016 rst=1 SHALL asynchronously force:
- state=IDLE, owner=00;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- i_ack=0, d_ack=0, starvation counter=0.
REQ-017 Reset asserted mid-BUSY SHALL drop mem_req immediately. No ack SHALL be issued for the aborted access, and a mem_ack arriving after reset SHALL be ignored (REQ-012).
REQ-018 The first grant after reset release SHALL occur at the first rising edge with rst=0 and a request present.

Verification
REQ-019 Single fetch: i_req=1, i_addr=0x0040_0000, memory acks 2 cycles after mem_req with rdata=0x2008_0005. Required: i_ack one cycle, i_rdata=0x2008_0005, i_stall=1 until the ack cycle, owner 00->01->00.
REQ-020 Conflict: i_req and d_req both rise in the same cycle, d_we=1, d_addr=0x1000_0004, d_wdata=0xDEAD_BEEF. Required: data granted first (mem_we=1, mem_addr=0x1000_0004), fetch granted after one IDLE cycle.
REQ-021 Starvation: i_req held high and d_req re-asserted every cycle after ack, STARVE_MAX=4, zero-latency memory. Required: 4 data grants, then 1 fetch grant, then the counter restarts.
REQ-022 Reset mid-access: assert rst in cycle 2 of BUSY_D, then pulse mem_ack one cycle after release. Required: mem_req=0 in the same cycle rst rises, no d_ack, owner=00.
REQ-023 Stray ack: mem_ack=1 in IDLE with no requests. Required: no ack pulses, owner stays 00.
REQ-024 Back-to-back data: d_req is re-presented with d_addr=0x1000_0008 in the cycle after a d_ack. Required: exactly one IDLE cycle, then mem_addr=0x1000_0008, with no duplicate grant in the first ack cycle.
